mem_ld_queue: RTL
=================

MEM_LD_QUEUE -- requirements
Module: mem_ld_queue

Interface
REQ-001 Parameter DATA_W, default 32, data width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 2, number of in-flight instructions held; power of 2, 2..8.
REQ-003 Parameter SIDE_W, default 64, width of the opaque sideband carried per entry (pc, rf_we, rf_waddr, csr/exception fields).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  EX stage offers an instruction.
REQ-007 in_allowin  out  1  queue accepts the offered instruction this cycle.
REQ-008 in_req  in  1  a data-SRAM request was issued for this instruction; load or store.
REQ-009 in_is_load  in  1  result comes from memory data.
REQ-010 in_size  in  2  0 byte, 1 half, 2 word, 3 dword.
REQ-011 in_unsigned  in  1  zero-extend instead of sign-extend.
REQ-012 in_addr_lo  in  log2(DATA_W/8)  low address bits for lane select.
REQ-013 in_result  in  DATA_W  ALU/counter result used when in_is_load=0.
REQ-014 in_side  in  SIDE_W  sideband, returned unchanged.
REQ-015 data_ok  in  1  one in-order data-SRAM response this cycle.
REQ-016 rdata  in  DATA_W  response data, valid with data_ok.
REQ-017 out_valid  out  1  head result ready for WB.
REQ-018 out_allowin  in  1  WB accepts; transfer when out_valid & out_allowin.
REQ-019 out_wdata  out  DATA_W  extracted/extended register write data.
REQ-020 out_side  out  SIDE_W  sideband of head entry.
REQ-021 flush  in  1  exception/ertn/refetch flush; kills all held entries.
REQ-022 occupancy  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-023 Entries shall be kept in a circular FIFO of DEPTH slots: head pointer, tail pointer and count, each wrapping modulo DEPTH.
REQ-024 in_allowin shall be (count < DEPTH) & ~flush; a full queue does not accept in the same cycle the head leaves.
REQ-025 An entry shall be written at tail when in_valid & in_allowin, with flag got=~in_req.
REQ-026 Each data_ok shall be consumed, in order, by the first cancel pending (see REQ-031); otherwise by the oldest entry with in_req=1 and got=0, which captures rdata and sets got=1.
REQ-027 data_ok with no cancel pending and no waiting entry is a protocol error; the queue shall ignore it.
REQ-028 out_valid shall be head valid & ~flush & (head got=1, or head waiting and data_ok targets head this cycle); bypass gives zero-cycle latency from data_ok to out_valid.
REQ-029 out_wdata: in_is_load=0 gives stored in_result; otherwise the lane of size in_size at byte offset in_addr_lo selected from the captured data, or from rdata on bypass, then sign-extended to DATA_W unless in_unsigned; half uses addr_lo[bit1 and above], word uses addr_lo[2] when DATA_W=64; size 3 with DATA_W=32 is treated as word.
REQ-030 A stored entry shall never be modified except by capturing rdata; stores (in_req=1, in_is_load=0) wait for data_ok, then output in_result.
REQ-031 On flush, all entries shall be invalidated at the next edge, pointers and count set to 0, and cancel_cnt updated to cancel_cnt + N_pend - data_ok, where N_pend counts valid entries with in_req=1 and got=0 before the edge; cancel_cnt is wide enough for 2*DEPTH.
REQ-032 While cancel_cnt > 0, each data_ok shall decrement it and be discarded; new entries may be accepted while cancel_cnt > 0.
REQ-033 Simultaneous accept and dequeue shall leave count unchanged; both pointers advance.
REQ-034 On flush, in_valid and out_allowin in that cycle are ignored and no transfer occurs.

Reset
REQ-035 While reset=1: count, head, tail, cancel_cnt = 0, all got flags = 0, out_valid = 0, in_allowin = 0, occupancy = 0; out_wdata and out_side are don't-care.
REQ-036 Reset applied mid-operation shall drop all entries and cancel_cnt immediately, with no pending responses retained.

Verification
REQ-037 DATA_W=32: load byte unsigned=0, addr_lo=3, rdata=0x80FF_1234 with data_ok while head and out_allowin=1 -> out_valid same cycle, out_wdata=0xFFFF_FF80.
REQ-038 DATA_W=64: load word unsigned=1, addr_lo=4, rdata=0x8765_4321_0000_0000 -> out_wdata=0x0000_0000_8765_4321.
REQ-039 DEPTH=2: accept two loads, no data_ok -> in_allowin=0, occupancy=2; two data_ok 0x11, 0x22 with out_allowin=0 then 1 -> outputs 0x11 then 0x22 in order.
REQ-040 Two waiting loads, flush with data_ok in the same cycle -> cancel_cnt=1, occupancy=0; next data_ok is discarded; a new load accepted after it receives the following data_ok.
REQ-041 Non-memory entry (in_req=0, in_result=0x1234) behind a waiting load -> not output until the load completes; outputs 0x1234 the cycle after.

Source files
------------

// File: rtl/mem_ld_queue.sv
`default_nettype none
// ------------------------------------------------------------------------
// mem_ld_queue: in-order memory result queue between EX and WB -- rev 1.0
// ------------------------------------------------------------------------
module mem_ld_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int SIDE_W = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_allowin,
    input  logic                        in_req,
    input  logic                        in_is_load,
    input  logic [1:0]                  in_size,
    input  logic                        in_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0] in_addr_lo,
    input  logic [DATA_W-1:0]           in_result,
    input  logic [SIDE_W-1:0]           in_side,
    input  logic                        data_ok,
    input  logic [DATA_W-1:0]           rdata,
    output logic                        out_valid,
    input  logic                        out_allowin,
    output logic [DATA_W-1:0]           out_wdata,
    output logic [SIDE_W-1:0]           out_side,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      occupancy
);
    localparam int AW   = $clog2(DATA_W / 8);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = PW + 2;
    localparam logic [AW-1:0] HALF_MASK = ~AW'(1);
    localparam logic [AW-1:0] WORD_MASK = AW'(DATA_W / 8 - 4);

    logic [PW-1:0]     head, tail;
    logic [CNTW-1:0]   count;
    logic [CW-1:0]     cancel_cnt;
    logic [DEPTH-1:0]  got_q;
    logic [DEPTH-1:0]  req_q, load_q, uns_q;
    logic [1:0]        size_q   [DEPTH];
    logic [AW-1:0]     addr_q   [DEPTH];
    logic [DATA_W-1:0] result_q [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [SIDE_W-1:0] side_q   [DEPTH];

    logic [PW-1:0]     slot, wait_idx;
    logic              wait_found;
    logic [CW-1:0]     n_pend;
    logic              cancel_busy, take_wait, head_byp, consumed;
    logic              in_fire, out_fire;

    // Oldest valid entry still waiting for its response, and how many wait.
    always_comb begin
        slot       = '0;
        wait_idx   = '0;
        wait_found = 1'b0;
        n_pend     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if (CNTW'(i) < count && req_q[slot] && !got_q[slot]) begin
                n_pend = n_pend + 1'b1;
                if (!wait_found) begin
                    wait_found = 1'b1;
                    wait_idx   = slot;
                end
            end
        end
    end

    assign cancel_busy = (cancel_cnt != '0);
    assign take_wait   = data_ok & ~cancel_busy & wait_found;
    assign consumed    = data_ok & (cancel_busy | wait_found);
    assign head_byp    = take_wait & (wait_idx == head);
    assign out_valid   = ~reset & ~flush & (count != '0) & (got_q[head] | head_byp);
    assign in_allowin  = ~reset & ~flush & (count < CNTW'(DEPTH));
    assign in_fire     = in_valid & in_allowin;
    assign out_fire    = out_valid & out_allowin;
    assign occupancy   = count;
    assign out_side    = side_q[head];

    logic [DATA_W-1:0] src, shifted, ext;
    logic [AW-1:0]     off;
    logic              fill;
    int                nb;

    // Lane select and extension; an un-captured head reads rdata directly.
    always_comb begin
        src     = got_q[head] ? data_q[head] : rdata;
        off     = '0;
        nb      = DATA_W;
        fill    = 1'b0;
        shifted = '0;
        ext     = '0;
        case (size_q[head])
            2'd0:    off = addr_q[head];
            2'd1:    off = addr_q[head] & HALF_MASK;
            2'd2:    off = addr_q[head] & WORD_MASK;
            default: off = '0;
        endcase
        shifted = src >> {off, 3'b000};
        case (size_q[head])
            2'd0:    begin nb = 8;      fill = ~uns_q[head] & shifted[7];        end
            2'd1:    begin nb = 16;     fill = ~uns_q[head] & shifted[15];       end
            2'd2:    begin nb = 32;     fill = ~uns_q[head] & shifted[31];       end
            default: begin nb = DATA_W; fill = ~uns_q[head] & shifted[DATA_W-1]; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < nb) ? shifted[i] : fill;
        end
        out_wdata = load_q[head] ? ext : result_q[head];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cancel_cnt <= '0;
            got_q      <= '0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            got_q      <= '0;
            cancel_cnt <= cancel_cnt + n_pend - CW'(consumed);
        end else begin
            if (cancel_busy && data_ok) cancel_cnt <= cancel_cnt - 1'b1;
            if (take_wait) got_q[wait_idx] <= 1'b1;
            if (in_fire) begin
                got_q[tail] <= ~in_req;
                tail        <= tail + 1'b1;
            end
            if (out_fire) head <= head + 1'b1;
            count <= count + CNTW'(in_fire) - CNTW'(out_fire);
        end
    end

    // Payload carries no reset; only slots counted by count are ever observed.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            req_q[tail]    <= in_req;
            load_q[tail]   <= in_is_load;
            uns_q[tail]    <= in_unsigned;
            size_q[tail]   <= in_size;
            addr_q[tail]   <= in_addr_lo;
            result_q[tail] <= in_result;
            side_q[tail]   <= in_side;
        end
        if (take_wait && !flush) data_q[wait_idx] <= rdata;
    end
endmodule
`default_nettype wire
